// File: rtl/gate_adder6_reg.sv
// Unsigned WIDTH-bit adder built from 3-bit carry-lookahead groups, with a
// combinational sum/carry and a one-cycle registered copy qualified by a valid flag.
module gate_adder6_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic [WIDTH-1:0] S_q,
  output logic             cout_q,
  output logic             out_valid
);

  localparam int NG = WIDTH / 3;

  generate
    if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_width_check
      $error("gate_adder6_reg: WIDTH must be a positive multiple of 3");
    end
  endgenerate

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  logic [WIDTH-1:0] s_p1;
  logic             cout_p1;
  logic             vld_p1;

  // Stage 0: bit generate/propagate, group lookahead, sum
  assign g = X & Y;
  assign p = X ^ Y;

  // Each group resolves its own internal carries from the group carry-in,
  // so no carry ripples across more than one gate level inside a group.
  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      localparam int B = 3 * gi;

      assign grp_g[gi] = g[B+2]
                       | (p[B+2] & g[B+1])
                       | (p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi] = p[B+2] & p[B+1] & p[B];

      assign c[B]   = grp_c[gi];
      assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
      assign c[B+2] = g[B+1]
                    | (p[B+1] & g[B])
                    | (p[B+1] & p[B] & grp_c[gi]);
    end
  endgenerate

  // Group carries flattened as sum-of-products: c[k] = OR_j (G[j] & P[j+1..k-1]).
  always_comb begin
    logic acc;
    logic term;
    grp_c = '0;
    for (int k = 1; k <= NG; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      grp_c[k] = acc;
    end
  end

  assign S    = p ^ c;
  assign cout = grp_c[NG];

  // Stage 1: registered result; data holds when no valid input arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_p1    <= '0;
      cout_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1    <= S;
        cout_p1 <= cout;
      end
    end
  end

  assign S_q       = s_p1;
  assign cout_q    = cout_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_gate_adder6_reg.sv
// Directed bench for gate_adder6_reg: reset, boundaries, hold, reset-wins,
// then every 6-bit operand pair on the combinational path.
module tb_gate_adder6_reg;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic [WIDTH-1:0] S_q;
  logic             cout_q;
  logic             out_valid;

  int nvec = 0;
  int nerr = 0;

  gate_adder6_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .Y         (Y),
    .in_valid  (in_valid),
    .S         (S),
    .cout      (cout),
    .S_q       (S_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_comb(input string tag, input logic [WIDTH-1:0] es, input logic ec);
    nvec++;
    assert (S === es && cout === ec)
    else begin
      nerr++;
      $error("FAIL %s: got S=%0d cout=%b, want S=%0d cout=%b", tag, S, cout, es, ec);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [WIDTH-1:0] es, input logic ec,
                         input logic ev);
    nvec++;
    assert (S_q === es && cout_q === ec && out_valid === ev)
    else begin
      nerr++;
      $error("FAIL %s: got S_q=%0d cout_q=%b out_valid=%b, want S_q=%0d cout_q=%b out_valid=%b",
             tag, S_q, cout_q, out_valid, es, ec, ev);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH:0] exp_sum;
    int             exh_err;

    // Reset held two cycles with a valid input present
    rst_n = 1'b0; in_valid = 1'b1; X = 6'd5; Y = 6'd7;
    #1;
    chk_comb("reset_comb0", 6'd12, 1'b0);
    step();
    chk_reg("reset_reg1", 6'd0, 1'b0, 1'b0);
    chk_comb("reset_comb1", 6'd12, 1'b0);
    step();
    chk_reg("reset_reg2", 6'd0, 1'b0, 1'b0);
    chk_comb("reset_comb2", 6'd12, 1'b0);

    // Wrap: all-ones + 1
    rst_n = 1'b1; X = 6'd63; Y = 6'd1; in_valid = 1'b1;
    #1;
    chk_comb("wrap_comb", 6'd0, 1'b1);
    step();
    chk_reg("wrap_reg", 6'd0, 1'b1, 1'b1);

    // Max + max
    X = 6'd63; Y = 6'd63;
    #1;
    chk_comb("max_comb", 6'd62, 1'b1);
    step();
    chk_reg("max_reg", 6'd62, 1'b1, 1'b1);

    // Zero + zero
    X = 6'd0; Y = 6'd0;
    #1;
    chk_comb("zero_comb", 6'd0, 1'b0);
    step();
    chk_reg("zero_reg", 6'd0, 1'b0, 1'b1);

    // Carry into the second lookahead group, then a no-carry pattern
    X = 6'd7; Y = 6'd1;
    #1;
    chk_comb("grp_carry_comb", 6'd8, 1'b0);
    step();
    chk_reg("grp_carry_reg", 6'd8, 1'b0, 1'b1);
    X = 6'd21; Y = 6'd42;
    #1;
    chk_comb("alt_bits_comb", 6'd63, 1'b0);
    step();
    chk_reg("alt_bits_reg", 6'd63, 1'b0, 1'b1);

    // Hold: registered result keeps 30 while inputs change without valid
    X = 6'd10; Y = 6'd20; in_valid = 1'b1;
    #1;
    chk_comb("hold_load_comb", 6'd30, 1'b0);
    step();
    chk_reg("hold_load_reg", 6'd30, 1'b0, 1'b1);
    X = 6'd1; Y = 6'd1; in_valid = 1'b0;
    #1;
    chk_comb("hold_comb", 6'd2, 1'b0);
    step();
    chk_reg("hold_reg1", 6'd30, 1'b0, 1'b0);
    step();
    chk_reg("hold_reg2", 6'd30, 1'b0, 1'b0);

    // Carry-out captured, then reset wins over in_valid in the same cycle
    X = 6'd40; Y = 6'd50; in_valid = 1'b1;
    step();
    chk_reg("pre_reset_reg", 6'd26, 1'b1, 1'b1);
    X = 6'd9; Y = 6'd9; rst_n = 1'b0;
    #1;
    chk_comb("reset_mid_comb", 6'd18, 1'b0);
    step();
    chk_reg("reset_mid_reg", 6'd0, 1'b0, 1'b0);
    rst_n = 1'b1; in_valid = 1'b0;

    // Exhaustive combinational sweep
    exh_err = nerr;
    for (int i = 0; i < (1 << (2 * WIDTH)); i++) begin
      X = i[2*WIDTH-1:WIDTH];
      Y = i[WIDTH-1:0];
      exp_sum = {1'b0, X} + {1'b0, Y};
      #1;
      nvec++;
      assert ({cout, S} === exp_sum)
      else begin
        nerr++;
        $error("FAIL exhaustive idx=%0d X=%0d Y=%0d: got %0d, want %0d",
               i, X, Y, {cout, S}, exp_sum);
      end
    end
    $display("exhaustive sweep: %0d vectors, %0d errors", 1 << (2 * WIDTH), nerr - exh_err);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
